// File: rtl/sdr_16_port_sched_pkg.sv
// sdr_16_port_sched_pkg
//   Definitions shared by the SDRAM port scheduler and the SDRAM control FSM.
//   - sdr_cmd_e : SDRAM command encodings as {ras_n, cas_n, we_n}
//   - MAX_PORTS : widest port vector the round-robin helper handles
//   - RFR_CNT_W : width of the refresh backlog counter
//   - RFR_TMR_W : width of the refresh interval timer
//   - rr_next() : one-hot next requester in cyclic order
package sdr_16_port_sched_pkg;

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000,
    CMD_RFR = 3'b001,
    CMD_PCH = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_NOP = 3'b111
  } sdr_cmd_e;

  localparam int MAX_PORTS = 8;
  localparam int RFR_CNT_W = 4;
  localparam int RFR_TMR_W = 16;

  // Search the first n ports cyclically, starting just after the current
  // grant. The current grant is the last candidate, so it is kept when it
  // is the only requester. With no requester at all the grant is held.
  // The search runs from the farthest candidate to the nearest one, so the
  // last hit is the closest requester.
  function automatic logic [MAX_PORTS-1:0] rr_next(
    input logic [MAX_PORTS-1:0] gnt,
    input logic [MAX_PORTS-1:0] req,
    input int                   n
  );
    logic [MAX_PORTS-1:0] res;
    int                   cur;
    int                   idx;
    res = gnt;
    cur = 0;
    idx = 0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (gnt[i]) cur = i;
    end
    for (int k = MAX_PORTS; k >= 1; k--) begin
      if (k <= n) begin
        idx = cur + k;
        if (idx >= n) idx = idx - n;
        if (req[idx]) res = MAX_PORTS'(1) << idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sdr_16_port_sched_rfr_timer.sv
// sdr_rfr_timer
//   Periodic auto-refresh request generator with a bounded backlog.
//   A free-running down-counter ticks every rfr_interval cycles. Each tick
//   adds one postponed refresh, and each cmd_aref issued by the FSM removes
//   one.
//   Ports:
//     sdram_clk   in   SDRAM-domain clock
//     sdram_rst   in   synchronous active-high reset
//     cmd_aref    in   one-cycle pulse, FSM issued an auto-refresh
//     refresh_req out  backlog is non-zero
//     rfr_pending out  current refresh backlog
//     rfr_overrun out  sticky, a tick was lost at full backlog
module sdr_rfr_timer
  import sdr_16_port_sched_pkg::*;
#(
  parameter int rfr_interval    = 390,
  parameter int rfr_max_pending = 8
) (
  input  logic                 sdram_clk,
  input  logic                 sdram_rst,
  input  logic                 cmd_aref,
  output logic                 refresh_req,
  output logic [RFR_CNT_W-1:0] rfr_pending,
  output logic                 rfr_overrun
);

  localparam logic [RFR_TMR_W-1:0] TMR_LOAD = RFR_TMR_W'(rfr_interval - 1);
  localparam logic [RFR_CNT_W-1:0] PEND_MAX = RFR_CNT_W'(rfr_max_pending);

  logic [RFR_TMR_W-1:0] tmr;
  logic                 tick;

  assign tick        = (tmr == '0);
  assign refresh_req = (rfr_pending != '0);

  // A tick and a cmd_aref in the same cycle cancel out. A cmd_aref with an
  // empty backlog comes from the init sequence and is ignored.
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      tmr         <= TMR_LOAD;
      rfr_pending <= '0;
      rfr_overrun <= 1'b0;
    end else begin
      tmr <= tick ? TMR_LOAD : tmr - 1'b1;
      if (tick && !cmd_aref) begin
        if (rfr_pending == PEND_MAX) rfr_overrun <= 1'b1;
        else                         rfr_pending <= rfr_pending + 1'b1;
      end else if (cmd_aref && !tick && rfr_pending != '0) begin
        rfr_pending <= rfr_pending - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdr_16_port_sched.sv
// sdr_16_port_sched
//   Shares the SDRAM control FSM between several egress FIFOs using
//   round-robin arbitration at transaction granularity. It also hosts the
//   auto-refresh request generator.
//   Ports:
//     sdram_clk   in   SDRAM-domain clock
//     sdram_rst   in   synchronous active-high reset
//     port_empty  in   per-port egress FIFO empty flags
//     port_sel    out  one-hot grant, steers the granted FIFO to the FSM
//     fifo_empty  out  empty flag of the granted port
//     state_idle  in   FSM is idle
//     fifo_rd_adr in   FSM fetches a transaction address
//     cmd_aref    in   FSM issued an auto-refresh
//     refresh_req out  refresh wanted
//     rfr_pending out  refresh backlog
//     rfr_overrun out  sticky refresh-lost flag
module sdr_16_port_sched
  import sdr_16_port_sched_pkg::*;
#(
  parameter int nr_of_ports     = 4,
  parameter int rfr_interval    = 390,
  parameter int rfr_max_pending = 8
) (
  input  logic                   sdram_clk,
  input  logic                   sdram_rst,
  input  logic [nr_of_ports-1:0] port_empty,
  output logic [nr_of_ports-1:0] port_sel,
  output logic                   fifo_empty,
  input  logic                   state_idle,
  input  logic                   fifo_rd_adr,
  input  logic                   cmd_aref,
  output logic                   refresh_req,
  output logic [3:0]             rfr_pending,
  output logic                   rfr_overrun
);

  localparam logic [nr_of_ports-1:0] GNT_RST = {{(nr_of_ports-1){1'b0}}, 1'b1};

  logic [nr_of_ports-1:0] gnt;
  logic [nr_of_ports-1:0] gnt_nxt;
  logic                   served;
  logic                   served_nxt;
  logic [MAX_PORTS-1:0]   gnt_wide;
  logic [MAX_PORTS-1:0]   req_wide;
  logic [MAX_PORTS-1:0]   rr_wide;

  assign port_sel   = gnt;
  // The grant is one-hot, so masking and OR-reducing selects the flag.
  assign fifo_empty = |(port_empty & gnt);

  always_comb begin
    gnt_wide                   = '0;
    gnt_wide[nr_of_ports-1:0]  = gnt;
    req_wide                   = '0;
    req_wide[nr_of_ports-1:0]  = ~port_empty;
    rr_wide                    = rr_next(gnt_wide, req_wide, nr_of_ports);
  end

  if (nr_of_ports < MAX_PORTS) begin : g_pad
    logic pad_unused;
    assign pad_unused = |rr_wide[MAX_PORTS-1:nr_of_ports];
  end

  // The grant only moves while the FSM is idle, so a started transaction
  // never loses its FIFO. A served port yields to the next requester. An
  // unserved empty port is skipped. An unserved non-empty port keeps the
  // grant because the FSM leaves idle on it in this very cycle.
  always_comb begin
    gnt_nxt    = gnt;
    served_nxt = served;
    if (fifo_rd_adr) served_nxt = 1'b1;
    if (state_idle) begin
      if (served) begin
        gnt_nxt    = rr_wide[nr_of_ports-1:0];
        served_nxt = 1'b0;
      end else if (fifo_empty) begin
        gnt_nxt = rr_wide[nr_of_ports-1:0];
      end
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      gnt    <= GNT_RST;
      served <= 1'b0;
    end else begin
      gnt    <= gnt_nxt;
      served <= served_nxt;
    end
  end

  sdr_rfr_timer #(
    .rfr_interval    (rfr_interval),
    .rfr_max_pending (rfr_max_pending)
  ) u_rfr_timer (
    .sdram_clk   (sdram_clk),
    .sdram_rst   (sdram_rst),
    .cmd_aref    (cmd_aref),
    .refresh_req (refresh_req),
    .rfr_pending (rfr_pending),
    .rfr_overrun (rfr_overrun)
  );

endmodule

// File: tb/tb_sdr_16_port_sched.sv
// tb_sdr_16_port_sched
//   Directed bench for the SDRAM port scheduler with 4 ports,
//   rfr_interval 390 and rfr_max_pending 8.
//   Inputs change on the falling edge, and outputs are checked on the
//   falling edge. cyc counts the rising edges since reset release, which
//   gives the cycle index of the state visible at each falling edge.
module tb_sdr_16_port_sched;

  logic       sdram_clk = 1'b0;
  logic       sdram_rst = 1'b1;
  logic [3:0] port_empty = 4'hF;
  logic       state_idle = 1'b0;
  logic       fifo_rd_adr = 1'b0;
  logic       cmd_aref = 1'b0;
  logic [3:0] port_sel;
  logic       fifo_empty;
  logic       refresh_req;
  logic [3:0] rfr_pending;
  logic       rfr_overrun;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;
  int expSel;

  sdr_16_port_sched #(
    .nr_of_ports     (4),
    .rfr_interval    (390),
    .rfr_max_pending (8)
  ) dut (
    .sdram_clk   (sdram_clk),
    .sdram_rst   (sdram_rst),
    .port_empty  (port_empty),
    .port_sel    (port_sel),
    .fifo_empty  (fifo_empty),
    .state_idle  (state_idle),
    .fifo_rd_adr (fifo_rd_adr),
    .cmd_aref    (cmd_aref),
    .refresh_req (refresh_req),
    .rfr_pending (rfr_pending),
    .rfr_overrun (rfr_overrun)
  );

  always #5 sdram_clk = ~sdram_clk;

  always @(posedge sdram_clk) begin
    if (sdram_rst) cyc <= 0;
    else           cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Drive one cycle's worth of inputs, then move to the next falling edge.
  task automatic applyStimulus(input logic [3:0] empty, input logic idle, input logic rdAdr, input logic aref);
    port_empty  = empty;
    state_idle  = idle;
    fifo_rd_adr = rdAdr;
    cmd_aref    = aref;
    @(negedge sdram_clk);
  endtask

  task automatic doReset();
    sdram_rst = 1'b1;
    repeat (2) @(negedge sdram_clk);
    sdram_rst = 1'b0;
  endtask

  task automatic waitCycle(input int target);
    checkOutput("wait_not_late", 32'(cyc <= target), 32'd1);
    while (cyc < target) @(negedge sdram_clk);
  endtask

  initial begin
    @(negedge sdram_clk);
    doReset();
    $display("[TB] reset state");
    checkOutput("rst_port_sel", port_sel, 4'b0001);
    checkOutput("rst_fifo_empty", fifo_empty, 1'b1);
    checkOutput("rst_refresh_req", refresh_req, 1'b0);
    checkOutput("rst_rfr_pending", rfr_pending, 4'd0);
    checkOutput("rst_rfr_overrun", rfr_overrun, 1'b0);

    $display("[TB] init-sequence arefs at empty backlog");
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b0);
    checkOutput("aref0_pending", rfr_pending, 4'd0);
    checkOutput("aref0_refresh_req", refresh_req, 1'b0);

    $display("[TB] skip and rotate with ports 1 and 3 busy");
    applyStimulus(4'b0101, 1'b1, 1'b0, 1'b0);
    checkOutput("skip_to_1", port_sel, 4'b0010);
    checkOutput("skip_fifo_empty", fifo_empty, 1'b0);
    applyStimulus(4'b0101, 1'b1, 1'b0, 1'b0);
    checkOutput("hold_1", port_sel, 4'b0010);
    applyStimulus(4'b0101, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b0101, 1'b0, 1'b0, 1'b0);
    checkOutput("frozen_busy", port_sel, 4'b0010);
    applyStimulus(4'b0111, 1'b0, 1'b0, 1'b0);
    checkOutput("frozen_emptied", port_sel, 4'b0010);
    checkOutput("frozen_fifo_empty", fifo_empty, 1'b1);
    applyStimulus(4'b0101, 1'b1, 1'b0, 1'b0);
    checkOutput("rotate_to_3", port_sel, 4'b1000);
    applyStimulus(4'b0101, 1'b1, 1'b0, 1'b0);
    checkOutput("hold_3", port_sel, 4'b1000);
    applyStimulus(4'hF, 1'b1, 1'b0, 1'b0);
    checkOutput("all_empty_hold", port_sel, 4'b1000);
    checkOutput("all_empty_fifo_empty", fifo_empty, 1'b1);

    $display("[TB] reset during a transaction");
    applyStimulus(4'b0101, 1'b0, 1'b1, 1'b0);
    port_empty  = 4'b0001;
    fifo_rd_adr = 1'b0;
    sdram_rst   = 1'b1;
    @(negedge sdram_clk);
    checkOutput("midrst_port_sel", port_sel, 4'b0001);
    checkOutput("midrst_fifo_empty", fifo_empty, 1'b1);
    sdram_rst = 1'b0;
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    checkOutput("midrst_served_clear", port_sel, 4'b0001);

    $display("[TB] round robin over four busy ports");
    for (int t = 0; t < 8; t++) begin
      expSel = 1 << (t % 4);
      checkOutput("rr_grant", port_sel, expSel);
      checkOutput("rr_fifo_empty", fifo_empty, 1'b0);
      applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
      checkOutput("rr_frozen_adr", port_sel, expSel);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
      checkOutput("rr_frozen_rw", port_sel, expSel);
      applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    end

    $display("[TB] first refresh tick");
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b0);
    waitCycle(389);
    checkOutput("tick_pre_req", refresh_req, 1'b0);
    checkOutput("tick_pre_pending", rfr_pending, 4'd0);
    @(negedge sdram_clk);
    checkOutput("tick1_req", refresh_req, 1'b1);
    checkOutput("tick1_pending", rfr_pending, 4'd1);
    waitCycle(780);
    checkOutput("tick2_pending", rfr_pending, 4'd2);

    $display("[TB] tick and aref together");
    waitCycle(1169);
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b1);
    cmd_aref = 1'b0;
    checkOutput("tick_aref_pending", rfr_pending, 4'd2);
    checkOutput("tick_aref_req", refresh_req, 1'b1);

    $display("[TB] backlog saturation");
    doReset();
    waitCycle(3120);
    checkOutput("sat8_pending", rfr_pending, 4'd8);
    checkOutput("sat8_overrun", rfr_overrun, 1'b0);
    waitCycle(3510);
    checkOutput("sat9_pending", rfr_pending, 4'd8);
    checkOutput("sat9_overrun", rfr_overrun, 1'b1);
    repeat (3) applyStimulus(4'hF, 1'b0, 1'b0, 1'b1);
    cmd_aref = 1'b0;
    checkOutput("drain3_pending", rfr_pending, 4'd5);
    checkOutput("drain3_overrun", rfr_overrun, 1'b1);
    checkOutput("drain3_req", refresh_req, 1'b1);
    repeat (5) applyStimulus(4'hF, 1'b0, 1'b0, 1'b1);
    cmd_aref = 1'b0;
    checkOutput("drain_all_pending", rfr_pending, 4'd0);
    checkOutput("drain_all_req", refresh_req, 1'b0);
    checkOutput("drain_all_overrun", rfr_overrun, 1'b1);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
